fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the control decoder: holds the PC, fetches from instruction memory over a req/ready handshake, and presents the instruction and its opcode field (instr[31:26]) to the decoder.
- Consumes the decoder's branch/jump flags plus execute-side results to compute the next PC (sequential, beq/bne/bgtz/blez/bltz, j/jal, jr).
- Multi-cycle: one instruction in flight; advances only on a downstream `advance` pulse.

---
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one instruction at a time over a
// req/ready handshake and computes the next PC when the decoder retires it.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        advance,
  input  logic        Branch,
  input  logic        Brchne,
  input  logic        Bgtz,
  input  logic        Blez,
  input  logic        Bltz,
  input  logic        Jump,
  input  logic        jr_en,
  input  logic        alu_zero,
  input  logic [31:0] rs_data,
  output logic        addr_err
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        req_q, req_d;
  logic        err_q, err_d;

  logic        taken;
  logic        rs_pos;
  logic        rs_zero;
  logic [31:0] seq_pc;
  logic [31:0] br_target;
  logic [31:0] next_pc;

  always_comb begin
    seq_pc    = pc_q + 32'd4;
    br_target = seq_pc + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    rs_zero   = ~(|rs_data);
    rs_pos    = ~rs_data[31] & ~rs_zero;
    taken     = (Branch & alu_zero) | (Brchne & ~alu_zero) | (Bgtz & rs_pos) |
                (Blez & (rs_data[31] | rs_zero)) | (Bltz & rs_data[31]);
  end

  // Priority chain keeps don't-care branch flags out of the PC on jumps.
  always_comb begin
    next_pc = seq_pc;
    if (jr_en) begin
      next_pc = {rs_data[31:2], 2'b00};
    end else if (Jump) begin
      next_pc = {seq_pc[31:28], instr_q[25:0], 2'b00};
    end else if (taken) begin
      next_pc = br_target;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    req_d   = req_q;
    err_d   = err_q;
    unique case (state_q)
      FETCH: begin
        // The request is raised one cycle after reset before any accept can occur.
        if (req_q && imem_ready) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = HOLD;
        end else begin
          req_d = 1'b1;
        end
      end
      HOLD: begin
        if (advance) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = FETCH;
          if (jr_en && (rs_data[1:0] != 2'b00)) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign pc          = pc_q;
  assign pc_plus4    = seq_pc;
  assign instr_valid = valid_q;
  assign addr_err    = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against an arithmetic next-PC model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        advance;
  logic        Branch, Brchne, Bgtz, Blez, Bltz, Jump, jr_en, alu_zero;
  logic [31:0] rs_data;
  logic        addr_err;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .instr(instr), .opcode(opcode), .pc(pc),
    .pc_plus4(pc_plus4), .instr_valid(instr_valid), .advance(advance),
    .Branch(Branch), .Brchne(Brchne), .Bgtz(Bgtz), .Blez(Blez), .Bltz(Bltz),
    .Jump(Jump), .jr_en(jr_en), .alu_zero(alu_zero), .rs_data(rs_data),
    .addr_err(addr_err)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_instr;
  logic        exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Next PC straight from the ISA rules: jr > j > taken branch > pc+4.
  function automatic logic [31:0] model_next(input logic [31:0] cur_pc, input logic [31:0] iw,
      input logic j, input logic jr, input logic br, input logic bne, input logic gtz,
      input logic lez, input logic ltz, input logic zero, input logic [31:0] rs);
    logic [31:0] seq;
    shortint     imm;
    int          s;
    logic [31:0] off;
    seq = cur_pc + 32'd4;
    if (jr) return rs & 32'hFFFF_FFFC;
    if (j) return (seq & 32'hF000_0000) | ((iw & 32'h03FF_FFFF) << 2);
    imm = iw[15:0];
    off = imm * 4;
    s   = rs;
    if ((br && zero) || (bne && !zero) || (gtz && s > 0) || (lez && s <= 0) || (ltz && s < 0))
      return seq + off;
    return seq;
  endfunction

  task automatic clear_flags();
    Branch = 0; Brchne = 0; Bgtz = 0; Blez = 0; Bltz = 0; Jump = 0; jr_en = 0;
    alu_zero = 0; rs_data = 32'h0; advance = 0;
  endtask

  // Called in HOLD, one tick after an edge; leaves the DUT refetching.
  task automatic retire(input logic j, input logic jr, input logic br, input logic bne,
      input logic gtz, input logic lez, input logic ltz, input logic zero, input logic [31:0] rs);
    logic [31:0] nxt;
    nxt = model_next(exp_pc, exp_instr, j, jr, br, bne, gtz, lez, ltz, zero, rs);
    if (jr && (rs % 4 != 0)) exp_err = 1'b1;
    Jump = j; jr_en = jr; Branch = br; Brchne = bne; Bgtz = gtz; Blez = lez; Bltz = ltz;
    alu_zero = zero; rs_data = rs; advance = 1'b1;
    @(posedge clk); #1;
    clear_flags();
    exp_pc = nxt;
    chk("next_pc", pc, exp_pc);
    chk1("valid_after_adv", instr_valid, 1'b0);
    chk1("req_after_adv", imem_req, 1'b1);
    chk1("addr_err", addr_err, exp_err);
    $display("retire j=%b jr=%b br=%b bne=%b gtz=%b lez=%b ltz=%b z=%b rs=%h -> pc=%h",
             j, jr, br, bne, gtz, lez, ltz, zero, rs, pc);
  endtask

  task automatic goto_pc(input logic [31:0] target);
    retire(0, 1, 0, 0, 0, 0, 0, 0, target);
  endtask

  // Called in FETCH with the request up; memory stalls for 'waits' cycles.
  task automatic fetch(input int waits, input logic [31:0] word);
    for (int i = 0; i <= waits; i++) begin
      chk1("req_wait", imem_req, 1'b1);
      chk("addr_wait", imem_addr, exp_pc);
      chk1("valid_wait", instr_valid, 1'b0);
      if (i < waits) begin
        imem_ready = 1'b0; imem_rdata = $urandom;
        @(posedge clk); #1;
      end
    end
    imem_ready = 1'b1; imem_rdata = word;
    @(posedge clk); #1;
    imem_ready = 1'b0; imem_rdata = $urandom;
    exp_instr = word;
    chk1("valid_fetch", instr_valid, 1'b1);
    chk("instr", instr, exp_instr);
    chk("opcode", {26'h0, opcode}, exp_instr >> 26);
    chk("pc_fetch", pc, exp_pc);
    chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
    chk1("req_hold", imem_req, 1'b0);
    $display("fetch pc=%h waits=%0d instr=%h", pc, waits, instr);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) begin
      imem_ready = 1'($urandom); imem_rdata = $urandom;
      @(posedge clk); #1;
      chk1("hold_valid", instr_valid, 1'b1);
      chk1("hold_req", imem_req, 1'b0);
      chk("hold_instr", instr, exp_instr);
      chk("hold_pc", pc, exp_pc);
    end
    imem_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] rs_tab [3];
    logic        tk;
    int          sel;
    rs_tab[0] = 32'h0; rs_tab[1] = 32'h1; rs_tab[2] = 32'h8000_0000;
    rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
    clear_flags();
    exp_pc = 32'h0; exp_instr = 32'h0; exp_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_valid", instr_valid, 1'b0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk1("rst_err", addr_err, 1'b0);

    // Zero-wait memory: valid two edges after release.
    rst_n = 1'b1; imem_ready = 1'b1; w = 32'hAC12_3456; imem_rdata = w;
    @(posedge clk); #1;
    chk1("boot_req", imem_req, 1'b1);
    chk("boot_addr", imem_addr, 32'h0);
    chk1("boot_valid_early", instr_valid, 1'b0);
    @(posedge clk); #1;
    imem_ready = 1'b0;
    exp_instr = w;
    chk1("boot_valid", instr_valid, 1'b1);
    chk("boot_instr", instr, w);
    chk("boot_opcode", {26'h0, opcode}, 32'h2B);
    $display("boot pc=%h instr=%h", pc, instr);
    hold(3);

    // Sequential advance then a stalled fetch.
    goto_pc(32'h10); fetch(0, 32'h0000_0000);
    retire(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    chk("seq_pc", imem_addr, 32'h14);
    fetch(3, 32'h2000_0001);

    // beq / bne with imm = -1 at 0x20.
    w = 32'h1022_FFFF;
    goto_pc(32'h20); fetch(0, w);
    retire(0, 0, 1, 0, 0, 0, 0, 1, 32'h0); chk("beq_taken", pc, 32'h20);
    fetch(1, w);
    retire(0, 0, 1, 0, 0, 0, 0, 0, 32'h0); chk("beq_not_taken", pc, 32'h24);
    w = 32'h1422_FFFF;
    fetch(0, w);
    goto_pc(32'h20); fetch(0, w);
    retire(0, 0, 0, 1, 0, 0, 0, 0, 32'h0); chk("bne_taken", pc, 32'h20);
    fetch(0, 32'h0);

    // bgtz / blez / bltz with imm = 4 at 0x40.
    for (int f = 0; f < 3; f++) begin
      for (int r = 0; r < 3; r++) begin
        goto_pc(32'h40); fetch(0, 32'h1C20_0004);
        tk = (f == 0) ? (r == 1) : (f == 1) ? (r != 1) : (r == 2);
        retire(0, 0, 0, 0, f == 0, f == 1, f == 2, 1'($urandom), rs_tab[r]);
        chk("signed_branch", pc, tk ? 32'h54 : 32'h44);
        fetch(0, $urandom);
      end
    end

    // PC wrap at the top of the address space.
    goto_pc(32'hFFFF_FFFC); fetch(0, 32'h0);
    chk("wrap_plus4", pc_plus4, 32'h0);
    retire(0, 0, 0, 0, 0, 0, 0, 0, 32'h0); chk("wrap_pc", pc, 32'h0);
    fetch(0, 32'h0);

    // Jump with undefined branch flags.
    goto_pc(32'h1000_0000); fetch(0, 32'h0800_0100);
    retire(1, 0, 1'bx, 1'bx, 1'bx, 1'bx, 1'bx, 1'bx, 32'h0);
    chk("jump_pc", pc, 32'h1000_0400);
    fetch(0, $urandom);

    // Misaligned jr sets the sticky error.
    goto_pc(32'h203); chk("jr_mis_pc", pc, 32'h200); chk1("jr_err", addr_err, 1'b1);
    fetch(0, $urandom);
    goto_pc(32'h300); chk1("err_sticky", addr_err, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      fetch($urandom_range(0, 3), $urandom);
      hold($urandom_range(0, 2));
      sel = $urandom_range(0, 9);
      if (sel == 0)
        retire(0, 1, 0, 0, 0, 0, 0, 0, $urandom);
      else if (sel == 1)
        retire(1, 0, 1'($urandom), 1'($urandom), 0, 0, 0, 1'($urandom), $urandom);
      else
        retire(0, 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0, 1'($urandom),
               (sel < 5) ? rs_tab[$urandom_range(0, 2)] : $urandom);
    end

    // Reset while waiting on memory.
    imem_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_pc = 32'h0; exp_err = 1'b0;
    chk1("midrst_req", imem_req, 1'b0);
    chk("midrst_pc", pc, 32'h0);
    chk1("midrst_valid", instr_valid, 1'b0);
    chk1("midrst_err", addr_err, 1'b0);
    $display("reset mid-fetch pc=%h req=%b", pc, imem_req);
    @(posedge clk); #1;
    fetch(1, 32'h8C01_0004);
    retire(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    fetch(0, $urandom);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
